// File: rtl/tdm_pkg.sv
// Shared types and slot geometry for the TDM demultiplexer sequencer.
// Defining TDM_PARITY_EN adds a ninth (parity) slot to every frame.
package tdm_pkg;

    typedef enum logic {IDLE, RUN} tdm_state_e;

    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned NUM_SLOTS = 8;

`ifdef TDM_PARITY_EN
    localparam int unsigned FRAME_SLOTS = NUM_SLOTS + 1;
    localparam int unsigned CNT_W       = SLOT_W + 1;
`else
    localparam int unsigned FRAME_SLOTS = NUM_SLOTS;
    localparam int unsigned CNT_W       = SLOT_W;
`endif

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_seq_if.sv
// Serial-in / demux-select-out bundle of tdm_demux_seq.
// With TDM_PARITY_EN defined the bundle also carries parity_err.
interface tdm_demux_seq_if;

    logic       din;
    logic       din_valid;
    logic       sync;
    logic       y;
    logic       s2;
    logic       s1;
    logic       s0;
    logic [7:0] frame;
    logic       frame_valid;
    logic       slot_err;
`ifdef TDM_PARITY_EN
    logic       parity_err;

    modport master (
        output din, din_valid, sync,
        input  y, s2, s1, s0, frame, frame_valid, slot_err, parity_err
    );

    modport slave (
        input  din, din_valid, sync,
        output y, s2, s1, s0, frame, frame_valid, slot_err, parity_err
    );
`else
    modport master (
        output din, din_valid, sync,
        input  y, s2, s1, s0, frame, frame_valid, slot_err
    );

    modport slave (
        input  din, din_valid, sync,
        output y, s2, s1, s0, frame, frame_valid, slot_err
    );
`endif

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot counter: advances on accepted bits, wraps at the frame end and realigns on sync.
// Frame length (8 or 9 slots) follows TDM_PARITY_EN through tdm_pkg.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             valid_i,
    input  logic             sync_i,
    input  logic             timeout_i,
    output logic [CNT_W-1:0] slot_o,
    output logic [CNT_W-1:0] acc_slot_o,
    output logic             accept_o,
    output logic             misalign_o
);

    logic [CNT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d     = slot_q;
        accept_o   = valid_i & (sync_i | run_i);
        misalign_o = run_i & valid_i & sync_i & (slot_q != '0);
        // A sync always places its own bit in slot 0, whatever the counter says.
        acc_slot_o = sync_i ? '0 : slot_q;

        if (timeout_i) begin
            slot_d = '0;
        end else if (valid_i && sync_i) begin
            slot_d = CNT_W'(1);
        end else if (valid_i && run_i) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_seq.sv
// Serial TDM frame sequencer driving a 1-to-8 demux, with frame capture and error pulses.
// Optional TDM_PARITY_EN: ninth even-parity slot and parity_err pulse.
module tdm_demux_seq
    import tdm_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    tdm_demux_seq_if.slave bus
);

    localparam logic [7:0] TO_LAST = 8'(IDLE_TIMEOUT - 1);

    tdm_state_e        state_q, state_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              y_q, y_d;
    logic [SLOT_W-1:0] sel_q, sel_d;
    logic [7:0]        frame_q, frame_d;
    logic              fv_q, fv_d;
    logic              err_q, err_d;
`ifdef TDM_PARITY_EN
    logic              perr_q, perr_d;
`endif

    logic             run;
    logic             timeout;
    logic             accept;
    logic             misalign;
    logic             data_slot;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] acc_slot;

    assign run     = (state_q == RUN);
    assign timeout = run & ~bus.din_valid & (to_cnt_q == TO_LAST);

    tdm_slot_counter u_slot (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .valid_i    (bus.din_valid),
        .sync_i     (bus.sync),
        .timeout_i  (timeout),
        .slot_o     (slot),
        .acc_slot_o (acc_slot),
        .accept_o   (accept),
        .misalign_o (misalign)
    );

`ifdef TDM_PARITY_EN
    assign data_slot = (acc_slot != CNT_W'(NUM_SLOTS));
`else
    assign data_slot = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        shift_d  = shift_q;
        y_d      = 1'b0;
        sel_d    = sel_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        err_d    = misalign | (timeout & (slot != '0));
`ifdef TDM_PARITY_EN
        perr_d   = 1'b0;
`endif

        if (run && !bus.din_valid && !timeout) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end

        unique case (state_q)
            IDLE: if (bus.din_valid && bus.sync) state_d = RUN;
            RUN:  if (timeout) state_d = IDLE;
        endcase

        if (accept) begin
            if (data_slot) begin
                y_d   = bus.din;
                sel_d = acc_slot[SLOT_W-1:0];
            end
            // Slot 0 restarts the partial frame, dropping any misaligned leftovers.
            if (acc_slot == '0) begin
                shift_d = {7'b0, bus.din};
            end else if (data_slot) begin
                shift_d[acc_slot[SLOT_W-1:0]] = bus.din;
            end
            if (acc_slot == LAST_SLOT) begin
                fv_d = 1'b1;
`ifdef TDM_PARITY_EN
                frame_d = shift_q;
                perr_d  = bus.din ^ (^shift_q);
`else
                frame_d = {bus.din, shift_q[6:0]};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            shift_q  <= '0;
            y_q      <= 1'b0;
            sel_q    <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            shift_q  <= shift_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
`ifdef TDM_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign bus.y                      = y_q;
    assign {bus.s2, bus.s1, bus.s0}   = sel_q;
    assign bus.frame                  = frame_q;
    assign bus.frame_valid            = fv_q;
    assign bus.slot_err               = err_q;
`ifdef TDM_PARITY_EN
    assign bus.parity_err             = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux_seq.sv
// Self-checking bench for tdm_demux_seq against a queue-based frame model.
// Honours TDM_PARITY_EN the same way as the design.
module tb_tdm_demux_seq;
    import tdm_pkg::*;

    localparam int TO = 16;
`ifdef TDM_PARITY_EN
    localparam int FRAME_LEN = 9;
    localparam int OW = 15;
`else
    localparam int FRAME_LEN = 8;
    localparam int OW = 14;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_seq_if bus ();

    tdm_demux_seq #(.IDLE_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int perr_cnt = 0;

    // Reference model: a frame is the queue of bits accepted since the last slot-0 bit.
    bit       running = 0;
    bit       q[$];
    int       stall = 0;
    logic     e_y = 0, e_fv = 0, e_err = 0, e_perr = 0;
    logic [2:0] e_sel = 0;
    logic [7:0] e_frame = 0;

    task automatic model_step(input logic d, input logic v, input logic s, input logic r);
        if (r) begin
            running = 0; q.delete(); stall = 0;
            e_y = 0; e_sel = 0; e_frame = 0; e_fv = 0; e_err = 0; e_perr = 0;
            return;
        end
        e_y = 0; e_fv = 0; e_err = 0; e_perr = 0;
        if (v) begin
            stall = 0;
            if (s) begin
                if (running && q.size() != 0) e_err = 1;
                q.delete();
                running = 1;
            end
            if (running) begin
                if (q.size() < 8) begin
                    e_y = d;
                    e_sel = 3'(q.size());
                end
                q.push_back(d);
                if (q.size() == FRAME_LEN) begin
                    for (int i = 0; i < 8; i++) e_frame[i] = q[i];
                    e_fv = 1;
`ifdef TDM_PARITY_EN
                    e_perr = q[8] ^ (^e_frame);
`endif
                    q.delete();
                end
            end
        end else if (running) begin
            stall++;
            if (stall == TO) begin
                e_err = (q.size() != 0);
                running = 0;
                q.delete();
                stall = 0;
            end
        end
    endtask

    function automatic logic [OW-1:0] exp_vec();
`ifdef TDM_PARITY_EN
        return {e_y, e_sel, e_frame, e_fv, e_err, e_perr};
`else
        return {e_y, e_sel, e_frame, e_fv, e_err};
`endif
    endfunction

    function automatic logic [OW-1:0] obs_vec();
`ifdef TDM_PARITY_EN
        return {bus.y, bus.s2, bus.s1, bus.s0, bus.frame, bus.frame_valid, bus.slot_err,
                bus.parity_err};
`else
        return {bus.y, bus.s2, bus.s1, bus.s0, bus.frame, bus.frame_valid, bus.slot_err};
`endif
    endfunction

    task automatic tick(input logic d, input logic v, input logic s, input logic r);
        bus.din = d; bus.din_valid = v; bus.sync = s; rst = r;
        @(posedge clk);
        model_step(d, v, s, r);
        #1;
        fv_cnt += int'(bus.frame_valid);
        err_cnt += int'(bus.slot_err);
`ifdef TDM_PARITY_EN
        perr_cnt += int'(bus.parity_err);
`endif
    endtask

    task automatic clear_counts();
        fv_cnt = 0; err_cnt = 0; perr_cnt = 0;
    endtask

    // Drives one whole frame starting with a sync; the parity slot (if any) carries par.
    task automatic send_frame(input logic [7:0] pat, input logic par);
        for (int i = 0; i < 8; i++) tick(pat[i], 1'b1, i == 0, 1'b0);
`ifdef TDM_PARITY_EN
        tick(par, 1'b1, 1'b0, 1'b0);
`else
        if (par) tick(1'b0, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d want=IDLE", dut.state_q);
        end
    endtask

    task automatic test_frame_4d();
        logic [7:0] pat = 8'h4D;
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            tick(pat[i], 1'b1, i == 0, 1'b0);
            checks++;
            if ({bus.y, bus.s2, bus.s1, bus.s0} !== {pat[i], 3'(i)}) begin
                errors++;
                $display("FAIL frame4d_slot%0d got=%b want=%b", i,
                         {bus.y, bus.s2, bus.s1, bus.s0}, {pat[i], 3'(i)});
            end
        end
`ifdef TDM_PARITY_EN
        tick(1'b0, 1'b1, 1'b0, 1'b0);
`endif
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.frame !== 8'h4D || fv_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL frame4d_result frame=%h fv=%0d err=%0d want frame=4d fv=1 err=0",
                     bus.frame, fv_cnt, err_cnt);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL frame4d_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_no_sync();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom), 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.y !== 1'b0 || dut.state_q !== IDLE) begin
                errors++;
                $display("FAIL nosync_idle y=%b state=%0d want y=0 IDLE", bus.y, dut.state_q);
            end
        end
        checks++;
        if (fv_cnt != 0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL nosync_result fv=%0d got=%h want fv=0 %h", fv_cnt, obs_vec(),
                     exp_vec());
        end
    endtask

    task automatic test_misalign();
        logic [7:0] pat = 8'($urandom);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 5; i++) tick(1'($urandom), 1'b1, i == 0, 1'b0);
        send_frame(pat, ^pat);
        checks++;
        if (err_cnt != 1 || fv_cnt != 1 || bus.frame !== pat) begin
            errors++;
            $display("FAIL misalign err=%0d fv=%0d frame=%h want err=1 fv=1 frame=%h",
                     err_cnt, fv_cnt, bus.frame, pat);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pat = 8'($urandom);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 3; i++) tick(pat[i], 1'b1, i == 0, 1'b0);
        for (int i = 0; i < TO - 1; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 8; i++) tick(pat[i], 1'b1, 1'b0, 1'b0);
`ifdef TDM_PARITY_EN
        tick(^pat, 1'b1, 1'b0, 1'b0);
`endif
        checks++;
        if (err_cnt != 0 || fv_cnt != 1 || bus.frame !== pat) begin
            errors++;
            $display("FAIL stall15 err=%0d fv=%0d frame=%h want err=0 fv=1 frame=%h",
                     err_cnt, fv_cnt, bus.frame, pat);
        end
        // Timeout at slot 0 goes quietly back to IDLE.
        clear_counts();
        for (int i = 0; i < TO; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cnt != 0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL timeout_slot0 err=%0d state=%0d want err=0 IDLE", err_cnt,
                     dut.state_q);
        end
        clear_counts();
        for (int i = 0; i < 3; i++) tick(pat[i], 1'b1, i == 0, 1'b0);
        for (int i = 0; i < TO; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cnt != 1 || fv_cnt != 0 || dut.state_q !== IDLE || bus.y !== 1'b0) begin
            errors++;
            $display("FAIL stall16 err=%0d fv=%0d state=%0d y=%b want err=1 fv=0 IDLE y=0",
                     err_cnt, fv_cnt, dut.state_q, bus.y);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0);
        clear_counts();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i == 0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== '0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid got=%h state=%0d want=0 IDLE", obs_vec(), dut.state_q);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fv_cnt != 0 || err_cnt != 0 || obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_pulses fv=%0d err=%0d got=%h want 0 0 0", fv_cnt,
                     err_cnt, obs_vec());
        end
    endtask

    task automatic test_random();
        int stall_left = 0;
        logic d, v, s, r;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            if (stall_left > 0) begin
                v = 0;
                stall_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                v = 0;
                stall_left = $urandom_range(0, 20);
            end else begin
                v = ($urandom_range(0, 4) != 0);
            end
            s = v && ($urandom_range(0, 9) == 0);
            d = 1'($urandom);
            tick(d, v, s, r);
            checks++;
            if (obs_vec() !== exp_vec() || (dut.state_q == RUN) !== running) begin
                errors++;
                $display("FAIL random_cycle%0d got=%h run=%b want=%h run=%b", n, obs_vec(),
                         dut.state_q == RUN, exp_vec(), running);
            end
        end
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        clear_counts();
        send_frame(8'h4D, 1'b0);
        checks++;
        if (perr_cnt != 0 || fv_cnt != 1 || bus.frame !== 8'h4D) begin
            errors++;
            $display("FAIL parity_good perr=%0d fv=%0d want perr=0 fv=1", perr_cnt, fv_cnt);
        end
        clear_counts();
        send_frame(8'h4D, 1'b1);
        checks++;
        if (bus.parity_err !== 1'b1 || bus.frame_valid !== 1'b1 || perr_cnt != 1) begin
            errors++;
            $display("FAIL parity_bad perr=%b fv=%b want perr=1 fv=1", bus.parity_err,
                     bus.frame_valid);
        end
    endtask
`endif

    initial begin
        bus.din = 0; bus.din_valid = 0; bus.sync = 0;
        test_reset();
        test_frame_4d();
        test_no_sync();
        test_misalign();
        test_timeout();
        test_reset_mid();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
